// File: rtl/commit_trace_pkg.sv
// ============================================================================
// commit_trace_pkg : shared entry layout and kind encoding for the trace queue
// Revision: 1.0
// ============================================================================
`default_nettype none

package commit_trace_pkg;

    // Entry fields are sized for the widest supported XLEN; narrower cores zero-extend.
    localparam int CT_MAX_XLEN = 64;

    typedef enum logic {
        KIND_COMMIT = 1'b0,
        KIND_TRAP   = 1'b1
    } kind_e;

    typedef struct packed {
        kind_e                  kind;
        logic [CT_MAX_XLEN-1:0] hartid;
        logic [CT_MAX_XLEN-1:0] pc;
        logic [31:0]            inst;
        logic [CT_MAX_XLEN-1:0] wdata;
        logic [CT_MAX_XLEN-1:0] mstatus;
        logic                   check;
        logic [CT_MAX_XLEN-1:0] cause;
        logic [31:0]            seq;
    } entry_t;

    function automatic entry_t make_trap(input logic [CT_MAX_XLEN-1:0] hartid,
                                         input logic [CT_MAX_XLEN-1:0] cause,
                                         input logic [31:0]            seq);
        entry_t e;
        e        = '0;
        e.kind   = KIND_TRAP;
        e.hartid = hartid;
        e.cause  = cause;
        e.seq    = seq;
        return e;
    endfunction

endpackage

`default_nettype wire

// File: rtl/commit_trace_mem.sv
// ============================================================================
// commit_trace_mem : multi-write-port, single async-read-port entry storage
// Revision: 1.0
// ============================================================================
`default_nettype none

module commit_trace_mem
    import commit_trace_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int NWP   = 3
) (
    input  logic                               clock,
    input  logic [NWP-1:0]                     wr_en_i,
    input  logic [NWP*$clog2(DEPTH)-1:0]       wr_addr_i,
    input  entry_t [NWP-1:0]                   wr_data_i,
    input  logic [$clog2(DEPTH)-1:0]           rd_addr_i,
    output entry_t                             rd_data_o
);

    localparam int AW = $clog2(DEPTH);

    // Storage is intentionally not reset; validity is tracked by the queue pointers.
    entry_t mem_q [DEPTH];

    always_ff @(posedge clock) begin
        for (int p = 0; p < NWP; p++) begin
            if (wr_en_i[p]) begin
                mem_q[wr_addr_i[p*AW +: AW]] <= wr_data_i[p];
            end
        end
    end

    assign rd_data_o = mem_q[rd_addr_i];

endmodule

`default_nettype wire

// File: rtl/commit_trace_serializer.sv
// ============================================================================
// commit_trace_serializer : packs multi-lane commit/trap bundles into a queue
//                           and emits them one event per cycle with a seq tag
// Revision: 1.0
// ============================================================================
`default_nettype none

module commit_trace_serializer
    import commit_trace_pkg::*;
#(
    parameter int          COMMIT_WIDTH = 2,
    parameter int          XLEN         = 64,
    parameter int          DEPTH        = 8,
    parameter logic [31:0] SEQ_INIT     = 32'h0
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic [COMMIT_WIDTH-1:0]      in_valid,
    input  logic [XLEN-1:0]              in_hartid,
    input  logic [XLEN*COMMIT_WIDTH-1:0] in_pc,
    input  logic [XLEN*COMMIT_WIDTH-1:0] in_wdata,
    input  logic [XLEN*COMMIT_WIDTH-1:0] in_mstatus,
    input  logic [32*COMMIT_WIDTH-1:0]   in_inst,
    input  logic [COMMIT_WIDTH-1:0]      in_check,
    input  logic                         in_int_xcpt,
    input  logic [XLEN-1:0]              in_cause,
    output logic                         in_ready,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic                         out_kind,
    output logic [XLEN-1:0]              out_hartid,
    output logic [XLEN-1:0]              out_pc,
    output logic [XLEN-1:0]              out_wdata,
    output logic [XLEN-1:0]              out_mstatus,
    output logic [XLEN-1:0]              out_cause,
    output logic [31:0]                  out_inst,
    output logic                         out_check,
    output logic [31:0]                  out_seq,
    output logic [$clog2(DEPTH):0]       count
);

    localparam int AW   = $clog2(DEPTH);
    localparam int CNTW = AW + 1;
    localparam int NWP  = COMMIT_WIDTH + 1;

    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNTW-1:0] count_q,  count_d;
    logic [31:0]     seq_q,    seq_d;

    logic            w_present;
    logic            w_accept;
    logic            w_deq;
    logic [2:0]      w_lane_off;
    logic [2:0]      w_n_enq;
    logic [NWP-1:0]  w_en;
    logic [NWP*AW-1:0] w_addr;
    entry_t [NWP-1:0]  w_data;
    entry_t          w_head;

    // in_ready depends only on registered occupancy, never on in_*.
    assign in_ready  = (CNTW'(DEPTH) - count_q) >= CNTW'(COMMIT_WIDTH + 1);
    assign w_present = (|in_valid) | in_int_xcpt;
    assign w_accept  = w_present & in_ready;
    assign out_valid = (count_q != '0);
    assign w_deq     = out_valid & out_ready;

    // Valid lanes are compacted into consecutive slots; the trap slot follows them.
    always_comb begin
        w_en       = '0;
        w_addr     = '0;
        w_data     = '0;
        w_lane_off = '0;
        for (int i = 0; i < COMMIT_WIDTH; i++) begin
            w_en[i]               = w_accept & in_valid[i];
            w_addr[i*AW +: AW]    = wr_ptr_q + AW'(w_lane_off);
            w_data[i].kind        = KIND_COMMIT;
            w_data[i].hartid      = CT_MAX_XLEN'(in_hartid);
            w_data[i].pc          = CT_MAX_XLEN'(in_pc[i*XLEN +: XLEN]);
            w_data[i].inst        = in_inst[i*32 +: 32];
            w_data[i].wdata       = CT_MAX_XLEN'(in_wdata[i*XLEN +: XLEN]);
            w_data[i].mstatus     = CT_MAX_XLEN'(in_mstatus[i*XLEN +: XLEN]);
            w_data[i].check       = in_check[i];
            w_data[i].cause       = '0;
            w_data[i].seq         = seq_q + 32'(w_lane_off);
            w_lane_off            = w_lane_off + {2'b00, in_valid[i]};
        end
        w_en[COMMIT_WIDTH]                   = w_accept & in_int_xcpt;
        w_addr[COMMIT_WIDTH*AW +: AW]        = wr_ptr_q + AW'(w_lane_off);
        w_data[COMMIT_WIDTH]                 = make_trap(CT_MAX_XLEN'(in_hartid),
                                                         CT_MAX_XLEN'(in_cause),
                                                         seq_q + 32'(w_lane_off));
        w_n_enq = w_accept ? (w_lane_off + {2'b00, in_int_xcpt}) : 3'd0;
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q + AW'(w_n_enq);
        rd_ptr_d = rd_ptr_q + AW'(w_deq);
        count_d  = count_q + CNTW'(w_n_enq) - CNTW'(w_deq);
        seq_d    = seq_q + 32'(w_n_enq);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            seq_q    <= SEQ_INIT;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            seq_q    <= seq_d;
        end
    end

    commit_trace_mem #(
        .DEPTH (DEPTH),
        .NWP   (NWP)
    ) u_mem (
        .clock     (clock),
        .wr_en_i   (w_en),
        .wr_addr_i (w_addr),
        .wr_data_i (w_data),
        .rd_addr_i (rd_ptr_q),
        .rd_data_o (w_head)
    );

    assign out_kind    = w_head.kind;
    assign out_hartid  = w_head.hartid[XLEN-1:0];
    assign out_pc      = w_head.pc[XLEN-1:0];
    assign out_wdata   = w_head.wdata[XLEN-1:0];
    assign out_mstatus = w_head.mstatus[XLEN-1:0];
    assign out_cause   = w_head.cause[XLEN-1:0];
    assign out_inst    = w_head.inst;
    assign out_check   = w_head.check;
    assign out_seq     = w_head.seq;
    assign count       = count_q;

endmodule

`default_nettype wire
